boot_loader: RTL
================

# boot_loader

Parametrised memory and register-file initialiser for the pipelined CPU. It replaces hierarchical preloading of instruction memory, data memory and the register file with a synthesizable command stream. Commands arrive over a valid/ready word interface, and the block issues one write per cycle to a selectable memory channel. It zero-clears the register file after reset and holds the CPU in reset until a RUN command is accepted.

## Interface
- DATA_W, 32: stream word and memory data width (≥ 24).
- ADDR_W, 10: memory word-address width; addresses wrap modulo 2^ADDR_W.
- NUM_MEM, 2: number of memory channels (channel 0 = instruction memory, channel 1 = data memory).
- LEN_W, 16: width of the transfer-length field.
- REG_COUNT, 32: register-file entries cleared after reset.
- REG_AW, 5: register-file address width.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  stream word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  DATA_W  command, length or payload word.
- mem_we  out  NUM_MEM  one-hot write enable per channel.
- mem_addr  out  ADDR_W  shared write address.
- mem_wdata  out  DATA_W  shared write data.
- reg_we  out  1  register-file write enable.
- reg_addr  out  REG_AW  register index.
- reg_wdata  out  32  always 0.
- cpu_reset  out  1  CPU hold-in-reset.
- done  out  1  RUN reached.
- err  out  1  sticky protocol error.

## Operation
- A word is accepted when in_valid and in_ready are both high.
- Command word fields:
  - in_data[DATA_W-1:DATA_W-4]: op. 1 = LOAD, 2 = FILL, 3 = RUN; any other value is illegal.
  - in_data[DATA_W-5:DATA_W-8]: channel.
  - in_data[ADDR_W-1:0]: start address.
- LOAD and FILL are followed by one length word; the count is in_data[LEN_W-1:0].
- State machine:
  - CLEAR: after Reset, writes 0 to registers 0..REG_COUNT-1, one per cycle, then goes to CMD.
  - CMD: accepts a command word. LOAD or FILL goes to LEN, RUN goes to RUN. An illegal op, or a channel ≥ NUM_MEM, goes to ERR.
  - LEN: accepts the count. A count of 0 returns to CMD with no writes. Otherwise LOAD goes to LOAD and FILL goes to FILL.
  - LOAD: each accepted word is written to the selected channel at the current address. The address then increments and the count decrements. The last word returns to CMD.
  - FILL: writes 0 on consecutive cycles without consuming stream words, then returns to CMD.
  - RUN: terminal state. done = 1 and cpu_reset = 0.
  - ERR: terminal state. err = 1 and cpu_reset stays 1.
- Only Reset leaves RUN or ERR.
- in_ready = 1 only in CMD, LEN and LOAD.
- Address increments wrap from 2^ADDR_W-1 to 0. Counts are unsigned.

## Timing
- Reset values:
  - State CLEAR, in_ready 0.
  - mem_we 0, mem_addr 0, mem_wdata 0.
  - reg_we 0, reg_addr 0.
  - cpu_reset 1, done 0, err 0.
- All outputs are registered.
- CLEAR lasts exactly REG_COUNT cycles: reg_we is high with reg_addr 0..REG_COUNT-1. in_ready first rises in the cycle after the last clear write.
- LOAD: mem_we[ch] pulses in the cycle after each accepted payload word, carrying that word and its address. Back-to-back valid gives one write per cycle.
- FILL of N words: N consecutive write cycles starting the cycle after the length word is accepted. in_ready returns the cycle after the last write.
- RUN: cpu_reset falls and done rises in the cycle after the RUN command is accepted.
- ERR: err rises in the cycle after the offending command is accepted.
- At most one mem_we bit and reg_we are never high in the same cycle.
- Reset asserted mid-LOAD or mid-FILL: in the cycle after the Reset edge, all write enables are 0 and cpu_reset is 1. Remaining counts are discarded and CLEAR restarts.
- in_valid while in_ready = 0: the word is ignored, not buffered.

## Structure
- Package boot_loader_pkg holds:
  - the op encodings (OP_LOAD, OP_FILL, OP_RUN);
  - the state enum;
  - the field-position constants for the op, channel and address fields.
- One sub-module, boot_wr_ctr: a loadable address/count counter with wrap and a last-beat flag, used for both LOAD and FILL.
- No memory arrays live inside this block.

## Test plan
- Reset released, in_valid 0 -> 32 cycles of reg_we with reg_addr 0..31 and data 0. in_ready stays 0 for those 32 cycles, then goes to 1.
- LOAD ch 0, address 0, length 3, payload 8c030000/8c040001/8c050002 sent back-to-back -> mem_we[0] high for 3 consecutive cycles at addresses 0, 1, 2 with those data.
- FILL ch 1, address 0x3FE, length 4 -> mem_we[1] writes 0 at 0x3FE, 0x3FF, 0x000, 0x001. in_ready is 0 throughout.
- Command with channel 5 (NUM_MEM = 2) -> err = 1 the next cycle. in_ready stays 0 and cpu_reset stays 1 until Reset; subsequent words produce no writes.
- LOAD of 2 words followed by RUN -> cpu_reset goes 1→0 and done goes 0→1 one cycle after RUN is accepted. A later in_valid is ignored.
- Reset pulsed after the 1st of 4 LOAD words -> no further mem_we. CLEAR restarts, cpu_reset = 1, and the remaining words are ignored until in_ready rises again.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared encodings for the boot loader: command ops, FSM states, command field layout.
// Header only; no logic, no latency, no flow control of its own.
package boot_loader_pkg;

    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_FILL = 4'd2;
    localparam logic [3:0] OP_RUN  = 4'd3;

    // Op sits in the top nibble, channel in the next nibble, address from bit 0.
    localparam int OP_W     = 4;
    localparam int CH_W     = 4;
    localparam int ADDR_LSB = 0;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_CMD,
        S_LEN,
        S_LOAD,
        S_FILL,
        S_RUN,
        S_ERR
    } state_t;

    function automatic logic ready_state(input state_t s);
        return (s == S_CMD) || (s == S_LEN) || (s == S_LOAD);
    endfunction

endpackage

// File: rtl/boot_wr_ctr.sv
// Loadable write-address / beat counter with wrap; last = one beat left, empty = none left.
// Updates one cycle after load/step; no flow control, the caller decides when to step.
module boot_wr_ctr #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              load_cnt,
    input  logic [LEN_W-1:0]  cnt_in,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              empty
);

    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            cnt  <= '0;
        end else begin
            if (load_addr)
                addr <= addr_in;
            else if (step)
                addr <= addr + ADDR_W'(1);

            // A load may coincide with the first beat, which is then consumed immediately.
            if (load_cnt)
                cnt <= cnt_in - LEN_W'(step);
            else if (step)
                cnt <= cnt - LEN_W'(1);
        end
    end

    assign last  = (cnt == LEN_W'(1));
    assign empty = (cnt == '0);

endmodule

// File: rtl/boot_loader.sv
// Command-stream memory/register-file initialiser; clears the register file, then LOAD/FILL/RUN.
// Writes appear one cycle after the accepting edge; in_ready only in CMD/LEN/LOAD, words otherwise ignored.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int NUM_MEM   = 2,
    parameter int LEN_W     = 16,
    parameter int REG_COUNT = 32,
    parameter int REG_AW    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic [NUM_MEM-1:0] mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               reg_we,
    output logic [REG_AW-1:0]  reg_addr,
    output logic [31:0]        reg_wdata,
    output logic               cpu_reset,
    output logic               done,
    output logic               err
);

    localparam int CLR_W = $clog2(REG_COUNT + 1);

    state_t            state, state_n;
    logic [CLR_W-1:0]  clr_cnt;
    logic [OP_W-1:0]   op_q;
    logic [CH_W-1:0]   ch_q;

    logic              fire;
    logic [OP_W-1:0]   op_in;
    logic [CH_W-1:0]   ch_in;
    logic [LEN_W-1:0]  len_in;
    logic [ADDR_W-1:0] addr_in;

    logic              ctr_load_addr, ctr_load_cnt, ctr_step;
    logic [ADDR_W-1:0] ctr_addr;
    logic              ctr_last, ctr_empty;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              clr_busy;

    assign fire      = in_valid && in_ready;
    assign op_in     = in_data[DATA_W-1 -: OP_W];
    assign ch_in     = in_data[DATA_W-OP_W-1 -: CH_W];
    assign len_in    = in_data[LEN_W-1:0];
    assign addr_in   = in_data[ADDR_LSB +: ADDR_W];
    assign clr_busy  = (state == S_CLEAR) && (clr_cnt != CLR_W'(REG_COUNT));
    assign reg_wdata = '0;

    boot_wr_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load_addr (ctr_load_addr),
        .addr_in   (addr_in),
        .load_cnt  (ctr_load_cnt),
        .cnt_in    (len_in),
        .step      (ctr_step),
        .addr      (ctr_addr),
        .last      (ctr_last),
        .empty     (ctr_empty)
    );

    always_comb begin
        state_n       = state;
        ctr_load_addr = 1'b0;
        ctr_load_cnt  = 1'b0;
        ctr_step      = 1'b0;
        wr_req        = 1'b0;
        wr_data       = '0;
        case (state)
            S_CLEAR: begin
                if (!clr_busy)
                    state_n = S_CMD;
            end
            S_CMD: begin
                if (fire) begin
                    ctr_load_addr = 1'b1;
                    if (int'(ch_in) >= NUM_MEM)
                        state_n = S_ERR;
                    else if (op_in == OP_LOAD || op_in == OP_FILL)
                        state_n = S_LEN;
                    else if (op_in == OP_RUN)
                        state_n = S_RUN;
                    else
                        state_n = S_ERR;
                end
            end
            S_LEN: begin
                if (fire) begin
                    if (len_in == '0) begin
                        state_n = S_CMD;
                    end else if (op_q == OP_LOAD) begin
                        ctr_load_cnt = 1'b1;
                        state_n      = S_LOAD;
                    end else begin
                        // First fill beat issues on the length edge so writes start next cycle.
                        ctr_load_cnt = 1'b1;
                        ctr_step     = 1'b1;
                        wr_req       = 1'b1;
                        state_n      = S_FILL;
                    end
                end
            end
            S_LOAD: begin
                if (fire) begin
                    wr_req   = 1'b1;
                    wr_data  = in_data;
                    ctr_step = 1'b1;
                    if (ctr_last)
                        state_n = S_CMD;
                end
            end
            S_FILL: begin
                if (ctr_empty) begin
                    state_n = S_CMD;
                end else begin
                    wr_req   = 1'b1;
                    ctr_step = 1'b1;
                end
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLEAR;
            clr_cnt   <= '0;
            op_q      <= '0;
            ch_q      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= state_n;
            in_ready <= ready_state(state_n);
            reg_we   <= clr_busy;
            if (clr_busy) begin
                reg_addr <= REG_AW'(clr_cnt);
                clr_cnt  <= clr_cnt + CLR_W'(1);
            end
            if (state == S_CMD && fire) begin
                op_q <= op_in;
                ch_q <= ch_in;
            end
            mem_we <= wr_req ? (NUM_MEM'(1) << ch_q) : '0;
            if (wr_req) begin
                mem_addr  <= ctr_addr;
                mem_wdata <= wr_data;
            end
            cpu_reset <= (state_n != S_RUN);
            done      <= (state_n == S_RUN);
            err       <= (state_n == S_ERR);
        end
    end

endmodule
